ajc_8bit_regfile_ccr_v: RTL and testbench

Register-file and condition-code stage wrapped around the 8-bit arithmetic unit.
- Upstream: supplies Operand_X/Operand_Y from a 4-entry register file.
- Downstream: consumes Arith_Result/Arith_CNVZ through a one-entry writeback pipeline register, then retires the result into the register file and a maskable condition-code register (CCR).
- Also provides same-cycle forwarding and a branch-condition evaluator.

---
 rtl/ajc_8bit_regfile_ccr_v_pkg.sv | 44 ++++
 rtl/ajc_8bit_regfile_ccr_v_if.sv | 34 +++
 rtl/ajc_8bit_regfile_ccr_v_cond_eval.sv | 37 +++
 rtl/ajc_8bit_regfile_ccr_v.sv | 94 +++++++++
 tb/tb_ajc_8bit_regfile_ccr_v.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ajc_8bit_regfile_ccr_v_pkg.sv
// Shared widths, flag bit positions, condition encodings and the writeback
// pipeline entry for the register-file / condition-code stage.
package ajc_8bit_regfile_ccr_v_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int ADDR_W = 2;
  localparam int FLAG_W = 4;

  // Bit positions inside a {C,N,V,Z} flag vector
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_N      = 3'd5,
    COND_V      = 3'd6,
    COND_LT     = 3'd7
  } cond_sel_e;

  // One pending writeback: destination, data, flags and per-flag update mask
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] cnvz;
    logic [FLAG_W-1:0] mask;
  } wb_entry_t;

  // Flags as they will look once the pending entry retires
  function automatic logic [FLAG_W-1:0] merge_flags(
    input logic [FLAG_W-1:0] ccr,
    input logic [FLAG_W-1:0] cnvz,
    input logic [FLAG_W-1:0] mask
  );
    return (ccr & ~mask) | (cnvz & mask);
  endfunction

endpackage

// File: rtl/ajc_8bit_regfile_ccr_v_if.sv
// Bus between the arithmetic pipeline and the register-file / CCR stage.
interface ajc_8bit_regfile_ccr_v_if;
  import ajc_8bit_regfile_ccr_v_pkg::*;

  logic [ADDR_W-1:0] rd_addr_x;
  logic [ADDR_W-1:0] rd_addr_y;
  logic [DATA_W-1:0] operand_x;
  logic [DATA_W-1:0] operand_y;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] arith_result;
  logic [FLAG_W-1:0] arith_cnvz;
  logic [FLAG_W-1:0] flag_mask;
  logic              stall;
  logic [FLAG_W-1:0] ccr;
  logic [2:0]        cond_sel;
  logic              cond_true;
  logic              pending;

  // Pipeline side: issues reads, writebacks and condition queries
  modport master (
    output rd_addr_x, rd_addr_y, wb_valid, wb_addr, arith_result,
           arith_cnvz, flag_mask, stall, cond_sel,
    input  operand_x, operand_y, ccr, cond_true, pending
  );

  // Register-file side
  modport slave (
    input  rd_addr_x, rd_addr_y, wb_valid, wb_addr, arith_result,
           arith_cnvz, flag_mask, stall, cond_sel,
    output operand_x, operand_y, ccr, cond_true, pending
  );

endinterface

// File: rtl/ajc_8bit_regfile_ccr_v_cond_eval.sv
// Combinational branch-condition evaluator working on the effective flags,
// i.e. the architectural CCR with any pending masked update merged in.
module ajc_cond_eval_v
  import ajc_8bit_regfile_ccr_v_pkg::*;
(
  input  logic [FLAG_W-1:0] ccr,
  input  logic              p_v,
  input  logic [FLAG_W-1:0] p_cnvz,
  input  logic [FLAG_W-1:0] p_mask,
  input  logic [2:0]        cond_sel,
  output logic              cond_true
);

  logic [FLAG_W-1:0] eff_flags;

  // Merge the in-flight flags so a branch right after a compare sees them
  always_comb begin
    eff_flags = p_v ? merge_flags(ccr, p_cnvz, p_mask) : ccr;
  end

  // Select the requested condition from the effective flags
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel_e'(cond_sel))
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = eff_flags[FLAG_Z];
      COND_NZ:     cond_true = ~eff_flags[FLAG_Z];
      COND_C:      cond_true = eff_flags[FLAG_C];
      COND_NC:     cond_true = ~eff_flags[FLAG_C];
      COND_N:      cond_true = eff_flags[FLAG_N];
      COND_V:      cond_true = eff_flags[FLAG_V];
      COND_LT:     cond_true = eff_flags[FLAG_N] ^ eff_flags[FLAG_V];
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ajc_8bit_regfile_ccr_v.sv
// Register file + condition-code register behind a one-entry writeback
// pipeline register. Reads bypass the pending entry; R0 is hardwired to zero.
module ajc_8bit_regfile_ccr_v
  import ajc_8bit_regfile_ccr_v_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  ajc_8bit_regfile_ccr_v_if.slave bus
);

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [FLAG_W-1:0] ccr_reg;
  wb_entry_t         p_reg;
  logic              p_v_reg;

  wb_entry_t         p_next;
  logic              retire_en;

  // A pending entry retires on any unstalled edge
  always_comb begin
    retire_en = p_v_reg & ~bus.stall;
    p_next    = '{addr: bus.wb_addr, data: bus.arith_result,
                  cnvz: bus.arith_cnvz, mask: bus.flag_mask};
  end

  // Capture stage: load a new request, or empty the stage when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      p_v_reg <= 1'b0;
    end else if (!bus.stall) begin
      p_v_reg <= bus.wb_valid;
      if (bus.wb_valid) begin
        p_reg <= p_next;
      end
    end
  end

  // Retire stage: write the data register; R0 writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (retire_en && (p_reg.addr != '0)) begin
      regs_reg[p_reg.addr] <= p_reg.data;
    end
  end

  // Retire stage: masked flag update, applied even for R0 destinations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr_reg <= '0;
    end else if (retire_en) begin
      ccr_reg <= merge_flags(ccr_reg, p_reg.cnvz, p_reg.mask);
    end
  end

  // Read port X: zero register, then bypass from the pending entry, then array
  always_comb begin
    bus.operand_x = regs_reg[bus.rd_addr_x];
    if (bus.rd_addr_x == '0) begin
      bus.operand_x = '0;
    end else if (p_v_reg && (p_reg.addr == bus.rd_addr_x)) begin
      bus.operand_x = p_reg.data;
    end
  end

  // Read port Y: same priority as port X, fully independent
  always_comb begin
    bus.operand_y = regs_reg[bus.rd_addr_y];
    if (bus.rd_addr_y == '0) begin
      bus.operand_y = '0;
    end else if (p_v_reg && (p_reg.addr == bus.rd_addr_y)) begin
      bus.operand_y = p_reg.data;
    end
  end

  // Architectural status outputs; CCR never shows bypassed flags
  always_comb begin
    bus.ccr     = ccr_reg;
    bus.pending = p_v_reg;
  end

  ajc_cond_eval_v u_cond_eval (
    .ccr       (ccr_reg),
    .p_v       (p_v_reg),
    .p_cnvz    (p_reg.cnvz),
    .p_mask    (p_reg.mask),
    .cond_sel  (bus.cond_sel),
    .cond_true (bus.cond_true)
  );

endmodule

// File: tb/tb_ajc_8bit_regfile_ccr_v.sv
// Directed bench for the register-file / CCR stage.
module tb_ajc_8bit_regfile_ccr_v;
  import ajc_8bit_regfile_ccr_v_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ajc_8bit_regfile_ccr_v_if bus_if ();

  ajc_8bit_regfile_ccr_v dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wb(input logic v, input logic [1:0] a, input logic [7:0] d,
                    input logic [3:0] f, input logic [3:0] m);
    bus_if.wb_valid     = v;
    bus_if.wb_addr      = a;
    bus_if.arith_result = d;
    bus_if.arith_cnvz   = f;
    bus_if.flag_mask    = m;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus_if.rd_addr_x = 2'd0;
    bus_if.rd_addr_y = 2'd0;
    bus_if.stall     = 1'b0;
    bus_if.cond_sel  = 3'd0;
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    tick();
    chk("rst_pending", {7'd0, bus_if.pending}, 8'h00);
    chk("rst_ccr", {4'd0, bus_if.ccr}, 8'h00);
    tick();
    rst = 1'b0;

    // Writeback R2 = 5A, flags 1000 fully unmasked
    wb(1'b1, 2'd2, 8'h5A, 4'b1000, 4'b1111);
    tick();
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    bus_if.rd_addr_x = 2'd2;
    bus_if.cond_sel  = 3'd3;
    #1;
    chk("byp_x_r2", bus_if.operand_x, 8'h5A);
    chk("byp_pending", {7'd0, bus_if.pending}, 8'h01);
    chk("byp_ccr_old", {4'd0, bus_if.ccr}, 8'h00);
    chk("byp_cond_c", {7'd0, bus_if.cond_true}, 8'h01);
    tick();
    chk("ret_ccr", {4'd0, bus_if.ccr}, 8'h08);
    chk("ret_pending", {7'd0, bus_if.pending}, 8'h00);
    chk("ret_x_r2", bus_if.operand_x, 8'h5A);

    // Write to R0: data dropped, Z flag still updates
    wb(1'b1, 2'd0, 8'hFF, 4'b0001, 4'b0001);
    bus_if.rd_addr_x = 2'd0;
    tick();
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    #1;
    chk("r0_pend_read", bus_if.operand_x, 8'h00);
    tick();
    bus_if.cond_sel = 3'd1;
    #1;
    chk("r0_read", bus_if.operand_x, 8'h00);
    chk("r0_ccr", {4'd0, bus_if.ccr}, 8'h09);
    chk("r0_cond_z", {7'd0, bus_if.cond_true}, 8'h01);

    // Back-to-back writes, no flag changes
    bus_if.rd_addr_x = 2'd1;
    bus_if.rd_addr_y = 2'd3;
    wb(1'b1, 2'd1, 8'h11, 4'hF, 4'h0);
    tick();
    chk("b2b_r1_11", bus_if.operand_x, 8'h11);
    wb(1'b1, 2'd1, 8'h22, 4'hF, 4'h0);
    tick();
    chk("b2b_r1_22", bus_if.operand_x, 8'h22);
    wb(1'b1, 2'd3, 8'h33, 4'hF, 4'h0);
    tick();
    chk("b2b_r1_arch", bus_if.operand_x, 8'h22);
    chk("b2b_r3_byp", bus_if.operand_y, 8'h33);
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    tick();
    chk("b2b_r3_arch", bus_if.operand_y, 8'h33);
    chk("b2b_pending", {7'd0, bus_if.pending}, 8'h00);
    chk("b2b_ccr", {4'd0, bus_if.ccr}, 8'h09);

    // Stall with R3 = 80 held while a different request is offered
    wb(1'b1, 2'd3, 8'h80, 4'h0, 4'h0);
    tick();
    bus_if.stall = 1'b1;
    wb(1'b1, 2'd3, 8'h99, 4'b0000, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_r3_byp", bus_if.operand_y, 8'h80);
      chk("stall_pending", {7'd0, bus_if.pending}, 8'h01);
      chk("stall_ccr", {4'd0, bus_if.ccr}, 8'h09);
    end
    bus_if.stall = 1'b0;
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    tick();
    chk("stall_r3_ret", bus_if.operand_y, 8'h80);
    chk("stall_pend_end", {7'd0, bus_if.pending}, 8'h00);
    chk("stall_ccr_end", {4'd0, bus_if.ccr}, 8'h09);

    // Masked flag update and condition evaluation
    wb(1'b1, 2'd0, 8'h00, 4'b0000, 4'b1111);
    tick();
    wb(1'b1, 2'd0, 8'h00, 4'b0110, 4'b0100);
    tick();
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    bus_if.cond_sel = 3'd5;
    #1;
    chk("mask_ccr_clr", {4'd0, bus_if.ccr}, 8'h00);
    chk("mask_byp_n", {7'd0, bus_if.cond_true}, 8'h01);
    tick();
    chk("mask_ccr", {4'd0, bus_if.ccr}, 8'h04);
    bus_if.cond_sel = 3'd7;
    #1;
    chk("cond_lt", {7'd0, bus_if.cond_true}, 8'h01);
    bus_if.cond_sel = 3'd6;
    #1;
    chk("cond_v", {7'd0, bus_if.cond_true}, 8'h00);
    bus_if.cond_sel = 3'd2;
    #1;
    chk("cond_nz", {7'd0, bus_if.cond_true}, 8'h01);
    bus_if.cond_sel = 3'd4;
    #1;
    chk("cond_nc", {7'd0, bus_if.cond_true}, 8'h01);
    bus_if.cond_sel = 3'd1;
    #1;
    chk("cond_z0", {7'd0, bus_if.cond_true}, 8'h00);

    // Asynchronous reset mid-stream with a write pending
    bus_if.rd_addr_x = 2'd1;
    bus_if.rd_addr_y = 2'd3;
    wb(1'b1, 2'd1, 8'h77, 4'hF, 4'hF);
    tick();
    wb(1'b0, 2'd0, 8'h00, 4'h0, 4'h0);
    chk("pre_rst_pend", {7'd0, bus_if.pending}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pending", {7'd0, bus_if.pending}, 8'h00);
    chk("arst_x_r1", bus_if.operand_x, 8'h00);
    chk("arst_y_r3", bus_if.operand_y, 8'h00);
    chk("arst_ccr", {4'd0, bus_if.ccr}, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_r1", bus_if.operand_x, 8'h00);
    chk("post_rst_ccr", {4'd0, bus_if.ccr}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
